seq_divider: RTL and testbench
==============================

# seq_divider

Sequential unsigned restoring divider; the inverse companion of the shift-add multiplier datapath in the arithmetic unit. It accepts a dividend and a divisor with a start pulse and produces one quotient bit per clock. It uses a split remainder/quotient register pair that shifts left, the mirror of the multiplier's right-shifting accumulator/multiplier pair. It sits beside the multiplier in the ALU and is controlled by the same start/done handshake style.

## Interface
Parameters:
- WIDTH, 4, operand/quotient/remainder width in bits (≥2)

Ports:
- clk  input  1  sole clock, all state on posedge
- rst_n  input  1  reset; one clock; reset is synchronous and active-low
- start  input  1  request; sampled only in IDLE
- dividend  input  WIDTH  unsigned dividend, captured on accepted start
- divisor  input  WIDTH  unsigned divisor, captured on accepted start
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse, high in DONE
- div_by_zero  output  1  result flag, valid from DONE until next accepted start
- quotient  output  WIDTH  result, valid from DONE until next accepted start
- remainder  output  WIDTH  result, valid from DONE until next accepted start

## Operation
- Internal state:
  - R, remainder register, WIDTH+1 bits (top)
  - Q, quotient register, WIDTH bits (bottom)
  - D, captured divisor, WIDTH bits
  - cnt, step counter, ceil(log2(WIDTH+1)) bits
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1, divisor≠0: R←0, Q←dividend, D←divisor, cnt←0, div_by_zero←0; go to RUN.
- IDLE, start=1, divisor=0: Q←all ones, R←{0,dividend}, div_by_zero←1; go to DONE.
- RUN, each cycle, one restoring step:
  - {R,Q} shifted left one bit as a 2·WIDTH+1-bit value.
  - trial = R_shifted − {1'b0,D}, computed (WIDTH+1)-bit.
  - trial MSB=0: R←trial, Q[0]←1. Otherwise R←R_shifted, Q[0]←0.
  - cnt increments. When cnt reaches WIDTH−1, this step is the last one; go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally. start during DONE is ignored.
- quotient = Q. remainder = R[WIDTH−1:0]; R[WIDTH] is always 0 after a completed step.
- start while busy or in DONE is ignored. Operands may change freely after acceptance.
- Results and div_by_zero hold their values in IDLE until the next accepted start.

## Timing
- Reset (rst_n=0 at posedge) values:
  - state=IDLE, busy=0, done=0, div_by_zero=0
  - quotient=0, remainder=0, R=Q=D=cnt=0
- Reset has priority over every other event, including mid-RUN and in DONE. It aborts the operation with no done pulse.
- Latency, start accepted at edge 0:
  - normal division: RUN during cycles 1..WIDTH, done high in cycle WIDTH+1 (after edge WIDTH), IDLE after edge WIDTH+1.
  - divide by zero: done high in cycle 1, IDLE after edge 1.
- Back-to-back throughput: next start can be accepted at the edge that leaves DONE → IDLE? No. start is sampled in IDLE only, so the minimum interval between starts is WIDTH+2 cycles.
- busy and done are registered, decoded directly from state, and never high together.

## Structure
- Package div_pkg: typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t; localparam function for counter width.
- Sub-module div_shift_reg holds the R/Q/D registers with load, load_dbz and step controls and the trial subtractor. The top level holds the FSM and counter.

## Test plan
- WIDTH=4, 13/4 → quotient=3, remainder=1, div_by_zero=0, done in cycle 5 after start edge, busy high in cycles 1–4.
- 15/1 → quotient=15, remainder=0; 7/9 → quotient=0, remainder=7; 0/5 → quotient=0, remainder=0.
- 9/0 → quotient=15, remainder=9, div_by_zero=1, done in cycle 1, busy never high.
- Second start with 2/1 asserted during cycles 2–5 of a 13/4 run → ignored; first result 3 r1 unaffected, no second done.
- rst_n=0 in cycle 3 of a run → next cycle IDLE, all outputs 0, no done. A new 6/3 afterwards gives quotient=2, remainder=0.
- Random sweep of all 256 operand pairs at WIDTH=4 against a reference model: quotient·divisor+remainder=dividend and remainder<divisor, for divisor≠0.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Start/done handshake and operand/result bundle of the divider.
interface seq_divider_if #(parameter int WIDTH = 4);

   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic             div_by_zero;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;

   modport master (
      output start, dividend, divisor,
      input  busy, done, div_by_zero, quotient, remainder
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, div_by_zero, quotient, remainder
   );

endinterface

// File: rtl/seq_divider_shift_reg.sv
// Remainder/quotient/divisor registers and the trial subtractor of one restoring step.
module div_shift_reg
   import div_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             load_dbz,
   input  logic             step,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   logic [WIDTH:0]   r_reg, r_next;
   logic [WIDTH-1:0] q_reg, q_next;
   logic [WIDTH-1:0] d_reg, d_next;
   logic             dbz_reg, dbz_next;

   logic [2*WIDTH:0] shifted;
   logic [WIDTH:0]   r_shift;
   logic [WIDTH:0]   trial;
   logic             take;

   // {R,Q} moves left as one word; the trial keeps a sign bit to detect borrow.
   assign shifted = {r_reg, q_reg} << 1;
   assign r_shift = shifted[2*WIDTH:WIDTH];
   assign trial   = r_shift - {1'b0, d_reg};
   assign take    = ~trial[WIDTH];

   always_comb begin
      r_next   = r_reg;
      q_next   = q_reg;
      d_next   = d_reg;
      dbz_next = dbz_reg;
      if (load) begin
         r_next   = '0;
         q_next   = dividend;
         d_next   = divisor;
         dbz_next = 1'b0;
      end else if (load_dbz) begin
         r_next   = {1'b0, dividend};
         q_next   = '1;
         dbz_next = 1'b1;
      end else if (step) begin
         r_next = take ? trial : r_shift;
         q_next = shifted[WIDTH-1:0] | WIDTH'(take);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_reg   <= '0;
         q_reg   <= '0;
         d_reg   <= '0;
         dbz_reg <= 1'b0;
      end else begin
         r_reg   <= r_next;
         q_reg   <= q_next;
         d_reg   <= d_next;
         dbz_reg <= dbz_next;
      end
   end

   assign quotient    = q_reg;
   assign remainder   = r_reg[WIDTH-1:0];
   assign div_by_zero = dbz_reg;

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/done handshake.
module seq_divider
   import div_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   seq_divider_if.slave  bus
);

   localparam int CW = cnt_width(WIDTH);

   div_state_t    state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic          load, load_dbz, step;

   logic [WIDTH-1:0] quotient_w, remainder_w;
   logic             dbz_w;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      load       = 1'b0;
      load_dbz   = 1'b0;
      step       = 1'b0;
      unique case (state_reg)
         IDLE: begin
            if (bus.start) begin
               if (bus.divisor == '0) begin
                  load_dbz   = 1'b1;
                  state_next = DONE;
               end else begin
                  load       = 1'b1;
                  cnt_next   = '0;
                  state_next = RUN;
               end
            end
         end
         RUN: begin
            step     = 1'b1;
            cnt_next = cnt_reg + 1'b1;
            if (cnt_reg == CW'(WIDTH - 1))
               state_next = DONE;
         end
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   div_shift_reg #(.WIDTH(WIDTH)) u_shift (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (load),
      .load_dbz    (load_dbz),
      .step        (step),
      .dividend    (bus.dividend),
      .divisor     (bus.divisor),
      .quotient    (quotient_w),
      .remainder   (remainder_w),
      .div_by_zero (dbz_w)
   );

   // Status flags come straight from the state register, so they are glitch-free.
   assign bus.busy        = (state_reg == RUN);
   assign bus.done        = (state_reg == DONE);
   assign bus.quotient    = quotient_w;
   assign bus.remainder   = remainder_w;
   assign bus.div_by_zero = dbz_w;

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector and sweep bench for seq_divider at WIDTH=4.
module tb_seq_divider;

   localparam int WIDTH = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   seq_divider_if #(.WIDTH(WIDTH)) bus ();

   seq_divider #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_vec  = 0;
   int n_miss = 0;

   typedef struct {
      int a;
      int b;
      int q;
      int r;
      int dbz;
      int done_cyc;
      int busy_cyc;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Apply one division and watch a fixed window of cycles after the accepting edge.
   task automatic run_div(input int a, input int b, input int eq, input int er,
                          input int edbz, input int edone, input int ebusy,
                          output int got_q, output int got_r);
      int done_cyc, n_done, n_busy, overlap;
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = WIDTH'(a);
      bus.divisor  = WIDTH'(b);
      @(posedge clk);
      #1;
      bus.start    = 1'b0;
      bus.dividend = ~WIDTH'(a);
      bus.divisor  = ~WIDTH'(b);
      done_cyc = 0; n_done = 0; n_busy = 0; overlap = 0;
      for (int k = 1; k <= WIDTH + 3; k++) begin
         @(negedge clk);
         if (bus.done) begin
            n_done++;
            if (done_cyc == 0) done_cyc = k;
         end
         if (bus.busy) n_busy++;
         if (bus.busy && bus.done) overlap++;
      end
      got_q = int'(bus.quotient);
      got_r = int'(bus.remainder);
      $display("div %0d/%0d -> q=%0d r=%0d dbz=%0d done@%0d busy=%0d",
               a, b, got_q, got_r, bus.div_by_zero, done_cyc, n_busy);
      check("done_cycle", done_cyc, edone);
      check("done_count", n_done, 1);
      check("busy_cycles", n_busy, ebusy);
      check("busy_done_overlap", overlap, 0);
      check("quotient", got_q, eq);
      check("remainder", got_r, er);
      check("div_by_zero", int'(bus.div_by_zero), edbz);
   endtask

   initial begin
      int gq, gr, done_cyc, n_done, n_busy;
      int eq, er;

      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      rst_n        = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_busy", int'(bus.busy), 0);
      check("reset_done", int'(bus.done), 0);
      check("reset_dbz", int'(bus.div_by_zero), 0);
      check("reset_quotient", int'(bus.quotient), 0);
      check("reset_remainder", int'(bus.remainder), 0);
      rst_n = 1'b1;

      vecs[0] = '{13, 4,  3, 1, 0, 5, 4};
      vecs[1] = '{15, 1, 15, 0, 0, 5, 4};
      vecs[2] = '{ 7, 9,  0, 7, 0, 5, 4};
      vecs[3] = '{ 0, 5,  0, 0, 0, 5, 4};
      vecs[4] = '{ 9, 0, 15, 9, 1, 1, 0};
      vecs[5] = '{12, 5,  2, 2, 0, 5, 4};
      vecs[6] = '{15, 15, 1, 0, 0, 5, 4};
      vecs[7] = '{ 1, 2,  0, 1, 0, 5, 4};
      vecs[8] = '{ 0, 0, 15, 0, 1, 1, 0};

      for (int i = 0; i < 9; i++)
         run_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz,
                 vecs[i].done_cyc, vecs[i].busy_cyc, gq, gr);

      // Second start during RUN and DONE of a 13/4 run must be ignored.
      @(negedge clk);
      bus.start = 1'b1; bus.dividend = 4'd13; bus.divisor = 4'd4;
      @(posedge clk);
      #1;
      bus.start = 1'b0; bus.dividend = 4'd2; bus.divisor = 4'd1;
      done_cyc = 0; n_done = 0; n_busy = 0;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         if (bus.done) begin
            n_done++;
            if (done_cyc == 0) done_cyc = k;
         end
         if (bus.busy) n_busy++;
         bus.start = (k >= 2 && k <= 5);
      end
      bus.start = 1'b0;
      $display("ignore-start 13/4 -> q=%0d r=%0d done@%0d dones=%0d busy=%0d",
               bus.quotient, bus.remainder, done_cyc, n_done, n_busy);
      check("ign_done_cycle", done_cyc, 5);
      check("ign_done_count", n_done, 1);
      check("ign_busy_cycles", n_busy, 4);
      check("ign_quotient", int'(bus.quotient), 3);
      check("ign_remainder", int'(bus.remainder), 1);

      // Reset in cycle 3 of a run aborts it without a done pulse.
      @(negedge clk);
      bus.start = 1'b1; bus.dividend = 4'd13; bus.divisor = 4'd4;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      n_done = 0;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (bus.done) n_done++;
         if (k == 3) rst_n = 1'b0;
         if (k == 4) begin
            check("abort_busy", int'(bus.busy), 0);
            check("abort_quotient", int'(bus.quotient), 0);
            check("abort_remainder", int'(bus.remainder), 0);
            check("abort_dbz", int'(bus.div_by_zero), 0);
            rst_n = 1'b1;
         end
      end
      $display("abort 13/4 -> dones=%0d", n_done);
      check("abort_done_count", n_done, 0);
      run_div(6, 3, 2, 0, 0, 5, 4, gq, gr);

      // Full operand sweep against integer division.
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            eq = (b == 0) ? 15 : a / b;
            er = (b == 0) ? a  : a % b;
            run_div(a, b, eq, er, (b == 0) ? 1 : 0, (b == 0) ? 1 : WIDTH + 1,
                    (b == 0) ? 0 : WIDTH, gq, gr);
            if (b != 0) begin
               check("identity", gq * b + gr, a);
               check("rem_lt_div", (gr < b) ? 1 : 0, 1);
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
